collision_probe_sequencer: RTL and testbench
============================================

Name: collision_probe_sequencer

Overview:
Parametrised successor to the fixed two-character collision probe loop. It snapshots the bounding boxes of NUM_CHAR characters and reads the collision-map ROM at four probe points per character (left, right, top, bottom). Sweeps run on request or free-running, and the whole result vector is published atomically with a done pulse. It sits between the character motion logic and the shared collision ROM, in the vga_clk domain.

Parameters:
NUM_CHAR, 2, number of characters probed per sweep (1..8)
ROM_LATENCY, 3, edges from rom_addr load to the edge that samples rom_data (2..7)
SCREEN_W, 640, map width in pixels; address = x + y*SCREEN_W
SCREEN_H, 480, map height in pixels
ADDR_W, 19, ROM address width
DATA_W, 3, ROM word (collision class) width
FREE_RUN, 1, 1 = auto-restart after each sweep; 0 = sweep only on start

Ports:
vga_clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high
start  in  1  sweep request, sampled in IDLE only
char_left  in  NUM_CHAR*10  per-char left x, char c at [c*10 +: 10]
char_right  in  NUM_CHAR*10  per-char right x
char_top  in  NUM_CHAR*10  per-char top y
char_bottom  in  NUM_CHAR*10  per-char bottom y
side_y_off  in  NUM_CHAR*10  y offset above bottom for left/right probes
mid_x_off  in  NUM_CHAR*10  x offset from left for top/bottom probes
rom_addr  out  ADDR_W  registered ROM address
rom_data  in  DATA_W  ROM read data
coll  out  NUM_CHAR*4*DATA_W  published results; probe k of char c at [(c*4+k)*DATA_W +: DATA_W], k: 0 = left, 1 = right, 2 = top, 3 = bottom
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse when coll is updated
overrun  out  1  one-cycle pulse when start is high while busy

Behaviour:
- States: IDLE, SNAP, PROBE.
- Reset (async): state IDLE; rom_addr, coll, the shadow buffer, the snapshot, the probe index and the wait counter all 0; busy = done = overrun = 0.
- IDLE: if FREE_RUN = 1, go to SNAP unconditionally on the first edge after reset deasserts. Otherwise go to SNAP on an edge where start = 1.
- SNAP (1 cycle): register all coordinate and offset inputs into the snapshot. Inputs changing later do not affect the sweep.
- PROBE, per probe p = 0..P-1, where P = 4*NUM_CHAR:
  - Order: char 0 left, right, top, bottom, then char 1, and so on.
  - On entry edge, load rom_addr with the probe p address.
  - Count ROM_LATENCY edges. The last counted edge writes rom_data into the shadow slot p and loads the address for probe p+1 on the same edge.
- Last probe: the capture edge also copies the shadow buffer into coll, with slot P-1 taking rom_data directly. The next cycle has done = 1.
  - FREE_RUN = 1: next state SNAP.
  - FREE_RUN = 0: next state IDLE.
- Latency: start edge E0 → SNAP → first address loaded at E1. coll is updated at E1 + P*ROM_LATENCY, with done high for the following cycle.
  - Defaults: coll updated at E0 + 25, done high 25 edges after E0.
  - FREE_RUN: sweep period is P*ROM_LATENCY + 1 cycles.
- coll changes only on publish edges, never partially. done is exactly one cycle.
- Probe coordinates, from snapshot, all unsigned 10-bit:
  - ys = bottom < side_y_off ? 0 : bottom - side_y_off.
  - left probe = (left, ys). right probe = (right, ys).
  - xm = left + mid_x_off, computed at 11 bits.
  - top probe = (xm, top >= SCREEN_H ? 0 : top). A value >= SCREEN_H is treated as underflow.
  - bottom probe = (xm, bottom >= SCREEN_H ? SCREEN_H-1 : bottom).
  - Any x >= SCREEN_W clamps to SCREEN_W-1. Any ys >= SCREEN_H clamps to SCREEN_H-1.
  - Address = x + y*SCREEN_W, truncated to ADDR_W.
- start while busy is ignored, and overrun pulses for each such cycle. start in IDLE with FREE_RUN = 1 is redundant and causes no error.
- Reset mid-sweep aborts immediately. coll returns to 0; no done is issued.

Test Plan:
- FREE_RUN = 0, defaults. ROM model returns addr[2:0] with a 3-edge latency. Char 0 L/R/T/B = 100/130/200/240, side_y_off = 15, mid_x_off = 13. → rom_addr sequence starts 100+225*640 = 144100, then 144130, 113+200*640 = 128113, 113+240*640 = 153713. done pulses 25 edges after the start edge; coll slots 0..3 = 4, 2, 1, 1.
- Underflow clamps: bottom = 10, side_y_off = 15, top = 1020, right = 700. → left probe y = 0, top probe y = 0, right probe x = 639.
- start pulsed on the cycle after start is accepted, and again mid-sweep → two overrun pulses, exactly one done, sweep timing unchanged.
- Snapshot isolation: change char_left three cycles into a sweep → that sweep's addresses use the old value, and the next sweep uses the new value.
- FREE_RUN = 1, NUM_CHAR = 3, ROM_LATENCY = 2. → done period is 25 cycles; busy stays high continuously after reset deasserts.
- Assert reset at cycle 10 of a sweep. → coll = 0, busy = 0, no done; the next start gives a full, correct sweep.

Source files
------------

// File: rtl/collision_probe_sequencer.sv
// collision_probe_sequencer
//   Snapshots the bounding boxes of NUM_CHAR characters and reads the shared
//   collision-map ROM at four probe points per character (left, right, top,
//   bottom). Results are gathered in a shadow buffer and published atomically
//   to coll, together with a one-cycle done pulse.
//
// Ports
//   vga_clk      clock, all state updates on rising edge
//   reset        asynchronous, active-high
//   start        sweep request, honoured in IDLE only
//   char_left    per-char left x,   char c at [c*10 +: 10]
//   char_right   per-char right x
//   char_top     per-char top y
//   char_bottom  per-char bottom y
//   side_y_off   y offset above bottom for the left/right probes
//   mid_x_off    x offset from left for the top/bottom probes
//   rom_addr     registered ROM address
//   rom_data     ROM read data, valid ROM_LATENCY edges after rom_addr loads
//   coll         published results, probe k of char c at [(c*4+k)*DATA_W +: DATA_W]
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse following each publish of coll
//   overrun      one-cycle pulse for each cycle start was high while busy
module collision_probe_sequencer #(
    parameter int NUM_CHAR    = 2,
    parameter int ROM_LATENCY = 3,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 3,
    parameter int FREE_RUN    = 1
) (
    input  logic                           vga_clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_CHAR*10-1:0]         char_left,
    input  logic [NUM_CHAR*10-1:0]         char_right,
    input  logic [NUM_CHAR*10-1:0]         char_top,
    input  logic [NUM_CHAR*10-1:0]         char_bottom,
    input  logic [NUM_CHAR*10-1:0]         side_y_off,
    input  logic [NUM_CHAR*10-1:0]         mid_x_off,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [DATA_W-1:0]              rom_data,
    output logic [NUM_CHAR*4*DATA_W-1:0]   coll,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);

    localparam int P  = 4 * NUM_CHAR;
    localparam int IW = 6;
    localparam int CW = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SNAP,
        S_PROBE
    } state_t;

    state_t                        r_state;
    logic [ADDR_W-1:0]             r_rom_addr;
    logic [NUM_CHAR*4*DATA_W-1:0]  r_coll;
    logic [NUM_CHAR*4*DATA_W-1:0]  r_shadow;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_overrun;
    logic [IW-1:0]                 r_idx;
    logic [CW-1:0]                 r_wait;
    logic [NUM_CHAR*10-1:0]        r_left;
    logic [NUM_CHAR*10-1:0]        r_right;
    logic [NUM_CHAR*10-1:0]        r_top;
    logic [NUM_CHAR*10-1:0]        r_bottom;
    logic [NUM_CHAR*10-1:0]        r_syo;
    logic [NUM_CHAR*10-1:0]        r_mxo;

    logic [IW-1:0]                 w_nidx;
    logic [3:0]                    w_nchar;
    logic [3:0]                    w_csel;
    logic [9:0]                    w_l, w_r, w_t, w_b, w_syo, w_mxo;
    logic [ADDR_W-1:0]             w_addr;
    logic [NUM_CHAR*4*DATA_W-1:0]  w_pub;

    function automatic logic [ADDR_W-1:0] probe_addr(
        input logic [9:0] l,
        input logic [9:0] r,
        input logic [9:0] t,
        input logic [9:0] b,
        input logic [9:0] syo,
        input logic [9:0] mxo,
        input logic [1:0] k
    );
        logic [9:0]  ys;
        logic [10:0] xm;
        logic [10:0] x;
        logic [9:0]  y;
        ys = (b < syo) ? '0 : b - syo;
        if ({1'b0, ys} >= 11'(SCREEN_H)) ys = 10'(SCREEN_H - 1);
        xm = {1'b0, l} + {1'b0, mxo};
        case (k)
            2'd0:    begin x = {1'b0, l}; y = ys; end
            2'd1:    begin x = {1'b0, r}; y = ys; end
            2'd2:    begin
                x = xm;
                // a top above the screen wraps to a large value; treat as row 0
                y = ({1'b0, t} >= 11'(SCREEN_H)) ? '0 : t;
            end
            default: begin
                x = xm;
                y = ({1'b0, b} >= 11'(SCREEN_H)) ? 10'(SCREEN_H - 1) : b;
            end
        endcase
        if (x >= 11'(SCREEN_W)) x = 11'(SCREEN_W - 1);
        return ADDR_W'(32'(x) + 32'(y) * 32'(SCREEN_W));
    endfunction

    // Address of the next probe to load. In SNAP the snapshot is being
    // written on the same edge, so probe 0 is taken from the live inputs.
    always_comb begin
        w_nidx  = (r_state == S_SNAP) ? '0 : r_idx + 1'b1;
        w_nchar = w_nidx[IW-1:2];
        w_csel  = (w_nchar < 4'(NUM_CHAR)) ? w_nchar : '0;
        if (r_state == S_SNAP) begin
            w_l   = char_left  [w_csel*10 +: 10];
            w_r   = char_right [w_csel*10 +: 10];
            w_t   = char_top   [w_csel*10 +: 10];
            w_b   = char_bottom[w_csel*10 +: 10];
            w_syo = side_y_off [w_csel*10 +: 10];
            w_mxo = mid_x_off  [w_csel*10 +: 10];
        end else begin
            w_l   = r_left  [w_csel*10 +: 10];
            w_r   = r_right [w_csel*10 +: 10];
            w_t   = r_top   [w_csel*10 +: 10];
            w_b   = r_bottom[w_csel*10 +: 10];
            w_syo = r_syo   [w_csel*10 +: 10];
            w_mxo = r_mxo   [w_csel*10 +: 10];
        end
        w_addr = probe_addr(w_l, w_r, w_t, w_b, w_syo, w_mxo, w_nidx[1:0]);
    end

    // Last slot bypasses the shadow so publish happens on the capture edge.
    always_comb begin
        w_pub = r_shadow;
        w_pub[(P-1)*DATA_W +: DATA_W] = rom_data;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rom_addr <= '0;
            r_coll     <= '0;
            r_shadow   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_idx      <= '0;
            r_wait     <= '0;
            r_left     <= '0;
            r_right    <= '0;
            r_top      <= '0;
            r_bottom   <= '0;
            r_syo      <= '0;
            r_mxo      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= start && r_busy;
            case (r_state)
                S_IDLE: begin
                    if ((FREE_RUN != 0) || start) begin
                        r_state <= S_SNAP;
                        r_busy  <= 1'b1;
                    end
                end
                S_SNAP: begin
                    r_left     <= char_left;
                    r_right    <= char_right;
                    r_top      <= char_top;
                    r_bottom   <= char_bottom;
                    r_syo      <= side_y_off;
                    r_mxo      <= mid_x_off;
                    r_rom_addr <= w_addr;
                    r_idx      <= '0;
                    r_wait     <= '0;
                    r_state    <= S_PROBE;
                end
                S_PROBE: begin
                    if (r_wait == CW'(ROM_LATENCY - 1)) begin
                        r_shadow[r_idx*DATA_W +: DATA_W] <= rom_data;
                        r_wait <= '0;
                        if (r_idx == IW'(P - 1)) begin
                            r_coll <= w_pub;
                            r_done <= 1'b1;
                            r_idx  <= '0;
                            if (FREE_RUN != 0) begin
                                r_state <= S_SNAP;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_idx      <= w_nidx;
                            r_rom_addr <= w_addr;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr = r_rom_addr;
    assign coll     = r_coll;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_collision_probe_sequencer.sv
module tb_collision_probe_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // shared character description, chars 0..2
    int L[3], R[3], T[3], B[3], SY[3], MX[3];

    // DUT 0: two chars, latency 3, on-request sweeps
    logic        rst0, start0;
    logic [19:0] l0, r0, t0, b0, sy0, mx0;
    logic [18:0] rom_addr0;
    logic [2:0]  rom_data0;
    logic [23:0] coll0;
    logic        busy0, done0, ovr0;
    logic [2:0]  rd0_a = '0, rd0_b = '0;

    // DUT 1: three chars, latency 2, free-running
    logic        rst1, start1;
    logic [29:0] l1, r1, t1, b1, sy1, mx1;
    logic [18:0] rom_addr1;
    logic [2:0]  rom_data1;
    logic [35:0] coll1;
    logic        busy1, done1, ovr1;
    logic [2:0]  rd1 = '0;

    collision_probe_sequencer #(.NUM_CHAR(2), .ROM_LATENCY(3), .FREE_RUN(0)) dut0 (
        .vga_clk(clk), .reset(rst0), .start(start0),
        .char_left(l0), .char_right(r0), .char_top(t0), .char_bottom(b0),
        .side_y_off(sy0), .mid_x_off(mx0),
        .rom_addr(rom_addr0), .rom_data(rom_data0), .coll(coll0),
        .busy(busy0), .done(done0), .overrun(ovr0));

    collision_probe_sequencer #(.NUM_CHAR(3), .ROM_LATENCY(2), .FREE_RUN(1)) dut1 (
        .vga_clk(clk), .reset(rst1), .start(start1),
        .char_left(l1), .char_right(r1), .char_top(t1), .char_bottom(b1),
        .side_y_off(sy1), .mid_x_off(mx1),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .coll(coll1),
        .busy(busy1), .done(done1), .overrun(ovr1));

    // ROM models: word = addr[2:0]; data valid LATENCY edges after the address
    always @(posedge clk) begin
        rd0_a <= rom_addr0[2:0];
        rd0_b <= rd0_a;
        rd1   <= rom_addr1[2:0];
    end
    assign rom_data0 = rd0_b;
    assign rom_data1 = rd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Probe address straight from the geometric rules (640x480 map)
    function automatic int unsigned maddr(int c, int k);
        int ys, x, y;
        ys = (B[c] < SY[c]) ? 0 : B[c] - SY[c];
        if (ys >= 480) ys = 479;
        case (k)
            0: begin x = L[c]; y = ys; end
            1: begin x = R[c]; y = ys; end
            2: begin x = L[c] + MX[c]; y = (T[c] >= 480) ? 0 : T[c]; end
            default: begin x = L[c] + MX[c]; y = (B[c] >= 480) ? 479 : B[c]; end
        endcase
        if (x >= 640) x = 639;
        return (x + y * 640) % (1 << 19);
    endfunction

    function automatic logic [63:0] mcoll(int nc);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < nc; c++)
            for (int k = 0; k < 4; k++)
                v[(c*4+k)*3 +: 3] = 3'(maddr(c, k) % 8);
        return v;
    endfunction

    task automatic pack();
        for (int c = 0; c < 2; c++) begin
            l0[c*10 +: 10] = 10'(L[c]);  r0[c*10 +: 10] = 10'(R[c]);
            t0[c*10 +: 10] = 10'(T[c]);  b0[c*10 +: 10] = 10'(B[c]);
            sy0[c*10 +: 10] = 10'(SY[c]); mx0[c*10 +: 10] = 10'(MX[c]);
        end
        for (int c = 0; c < 3; c++) begin
            l1[c*10 +: 10] = 10'(L[c]);  r1[c*10 +: 10] = 10'(R[c]);
            t1[c*10 +: 10] = 10'(T[c]);  b1[c*10 +: 10] = 10'(B[c]);
            sy1[c*10 +: 10] = 10'(SY[c]); mx1[c*10 +: 10] = 10'(MX[c]);
        end
    endtask

    task automatic randomize_chars();
        for (int c = 0; c < 3; c++) begin
            L[c] = $urandom_range(1023, 0); R[c] = $urandom_range(1023, 0);
            T[c] = $urandom_range(1023, 0); B[c] = $urandom_range(1023, 0);
            SY[c] = $urandom_range(1023, 0); MX[c] = $urandom_range(1023, 0);
        end
        pack();
    endtask

    logic [18:0] oa[8];

    // One on-request sweep of dut0. Extra start pulses before edges ov1/ov2
    // (relative to the accepting edge); char 0 left changes before edge chg_n.
    task automatic sweep0(input int ov1, input int ov2, input int chg_n, input int chg_val);
        int unsigned ea[8];
        logic [63:0] prev, expc;
        prev = 64'(coll0);
        for (int p = 0; p < 8; p++) ea[p] = maddr(p / 4, p % 4);
        expc = mcoll(2);
        @(negedge clk); start0 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start0 = (n == ov1) || (n == ov2);
            if (n == chg_n) begin L[0] = chg_val; pack(); end
            @(posedge clk); #1;
            chk($sformatf("done@%0d", n), 64'(done0), 64'(n == 25));
            chk($sformatf("overrun@%0d", n), 64'(ovr0), 64'((n == ov1) || (n == ov2)));
            chk($sformatf("busy@%0d", n), 64'(busy0), 64'(n < 25));
            chk($sformatf("coll@%0d", n), 64'(coll0), (n >= 25) ? expc : prev);
            if ((n - 1) % 3 == 0 && (n - 1) / 3 < 8) begin
                oa[(n - 1) / 3] = rom_addr0;
                chk($sformatf("addr_p%0d", (n - 1) / 3), 64'(rom_addr0), 64'(ea[(n - 1) / 3]));
            end
        end
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            L[c] = 0; R[c] = 0; T[c] = 0; B[c] = 0; SY[c] = 0; MX[c] = 0;
        end
        pack();
        #2 rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", 64'(rom_addr0), 64'd0);
        chk("rst_coll", 64'(coll0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_ovr", 64'(ovr0), 64'd0);
        chk("rst1_busy", 64'(busy1), 64'd0);
        @(negedge clk); rst0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("idle_no_start", 64'(busy0), 64'd0);

        // directed reference sweep
        randomize_chars();
        L[0] = 100; R[0] = 130; T[0] = 200; B[0] = 240; SY[0] = 15; MX[0] = 13;
        pack();
        sweep0(0, 0, 0, 0);
        chk("ref_a0", 64'(oa[0]), 64'd144100);
        chk("ref_a1", 64'(oa[1]), 64'd144130);
        chk("ref_a2", 64'(oa[2]), 64'd128113);
        chk("ref_a3", 64'(oa[3]), 64'd153713);
        chk("ref_slots", 64'(coll0[11:0]), 64'({3'd1, 3'd1, 3'd2, 3'd4}));

        // underflow / overflow clamps
        B[0] = 10; SY[0] = 15; T[0] = 1020; R[0] = 700;
        pack();
        sweep0(0, 0, 0, 0);
        chk("clamp_left", 64'(oa[0]), 64'd100);
        chk("clamp_right", 64'(oa[1]), 64'd639);
        chk("clamp_top", 64'(oa[2]), 64'd113);

        // overrun: start on the cycle after acceptance and mid-sweep
        randomize_chars();
        sweep0(1, 12, 0, 0);

        // snapshot isolation: char 0 left changes three cycles in
        randomize_chars();
        sweep0(0, 0, 3, (L[0] + 37) % 1024);
        sweep0(0, 0, 0, 0);

        // random sweeps
        for (int i = 0; i < 4; i++) begin
            randomize_chars();
            sweep0(0, 0, 0, 0);
        end

        // reset in the middle of a sweep
        randomize_chars();
        @(negedge clk); start0 = 1'b1;
        @(posedge clk);
        @(negedge clk); start0 = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst0 = 1'b1;
        #1;
        chk("midrst_coll", 64'(coll0), 64'd0);
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_done", 64'(done0), 64'd0);
        chk("midrst_addr", 64'(rom_addr0), 64'd0);
        @(negedge clk); rst0 = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            chk($sformatf("postrst_done@%0d", n), 64'(done0), 64'd0);
            chk($sformatf("postrst_busy@%0d", n), 64'(busy0), 64'd0);
        end
        randomize_chars();
        sweep0(0, 0, 0, 0);

        // free-running instance: 3 chars, latency 2, period 25
        randomize_chars();
        @(negedge clk); rst1 = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            chk($sformatf("fr_busy@%0d", n), 64'(busy1), 64'd1);
            chk($sformatf("fr_done@%0d", n), 64'(done1), 64'((n == 26) || (n == 51) || (n == 76)));
            chk($sformatf("fr_coll@%0d", n), 64'(coll1), (n < 26) ? 64'd0 : mcoll(3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
